// File: rtl/bfly_pkt_injector_if.sv
// Host-side descriptor/payload handshakes and the switch-facing flit channel
// of the butterfly packet injector, bundled as one interface.
//
// Handshake rule for both host channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. The source keeps valid and its
// payload stable until that edge. Ready depends only on injector state and
// never on valid. The flit channel has no backpressure.
interface bfly_pkt_injector_if #(
    parameter int CHANNEL_WIDTH = 18
);
    logic                     msg_valid;
    logic                     msg_ready;
    logic [5:0]               msg_dest;
    logic [3:0]               msg_len;
    logic                     data_valid;
    logic                     data_ready;
    logic [9:0]               data;
    logic [CHANNEL_WIDTH-1:0] out_ch;
    logic                     pkt_done;

    // Host side: drives descriptors and payload words, observes the flit channel.
    modport master (
        output msg_valid, msg_dest, msg_len, data_valid, data,
        input  msg_ready, data_ready, out_ch, pkt_done
    );

    // Injector side.
    modport slave (
        input  msg_valid, msg_dest, msg_len, data_valid, data,
        output msg_ready, data_ready, out_ch, pkt_done
    );
endinterface

// File: rtl/bfly_pkt_injector.sv
// Terminal-side packet source for the radix-4 butterfly. It turns a message
// descriptor plus a payload word stream into head/body/tail flits and emits
// one registered flit per cycle. Idle cycles and payload bubbles produce
// all-zero flits.
module bfly_pkt_injector #(
    parameter int         CHANNEL_WIDTH = 18,
    parameter logic [5:0] SRC_ID        = 6'd0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bfly_pkt_injector_if.slave      bus,
    output logic                    o_dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [5:0]               r_dest;
    logic [3:0]               r_len;
    logic [3:0]               r_cnt;
    logic [CHANNEL_WIDTH-1:0] r_out_ch;
    logic                     r_pkt_done;

    logic                     w_msg_ready;
    logic                     w_data_ready;
    logic                     w_msg_hs;
    logic                     w_data_hs;
    logic                     w_last_word;
    logic [CHANNEL_WIDTH-1:0] w_flit_nxt;
    logic                     w_done_nxt;

    // The handshakes are qualified by the ready signals. The ready signals
    // already include rst_n, so no transfer can be counted during reset.
    assign w_msg_hs    = bus.msg_valid  && w_msg_ready;
    assign w_data_hs   = bus.data_valid && w_data_ready;
    assign w_last_word = (r_cnt == r_len);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    // An open packet is left only by its tail word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_msg_hs) w_state_nxt = S_BODY;
            S_BODY: if (w_data_hs && w_last_word) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic.
    // This process drives the ready signals and selects the next flit.
    // A cycle with no accepted transfer produces the all-zero idle flit.
    always_comb begin
        w_msg_ready  = 1'b0;
        w_data_ready = 1'b0;
        w_flit_nxt   = '0;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_msg_ready = rst_n;
                if (w_msg_hs) begin
                    w_flit_nxt = {TYPE_HEAD, bus.msg_dest, bus.msg_len, SRC_ID};
                end
            end
            S_BODY: begin
                w_data_ready = rst_n;
                if (w_data_hs) begin
                    if (w_last_word) begin
                        w_flit_nxt = {TYPE_TAIL, r_dest, bus.data};
                        w_done_nxt = 1'b1;
                    end else begin
                        w_flit_nxt = {TYPE_BODY, r_dest, bus.data};
                    end
                end
            end
            default: begin
                w_flit_nxt = '0;
            end
        endcase
    end

    // Datapath registers.
    // These hold the flit channel, the done pulse, the latched descriptor and
    // the count of words accepted in the current packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_ch   <= '0;
            r_pkt_done <= 1'b0;
            r_dest     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
        end else begin
            r_out_ch   <= w_flit_nxt;
            r_pkt_done <= w_done_nxt;
            if (w_msg_hs) begin
                r_dest <= bus.msg_dest;
                r_len  <= bus.msg_len;
                r_cnt  <= '0;
            end else if (w_data_hs && !w_last_word) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign bus.msg_ready  = w_msg_ready;
    assign bus.data_ready = w_data_ready;
    assign bus.out_ch     = r_out_ch;
    assign bus.pkt_done   = r_pkt_done;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_bfly_pkt_injector.sv
// Directed bench for bfly_pkt_injector (SRC_ID = 5). Each step advances one
// clock and samples the outputs 1 ns after the rising edge. New inputs are
// then driven for the next edge.
module tb_bfly_pkt_injector;

    logic clk;
    logic rst_n;
    logic dbg_state;

    int n_checks;
    int n_errors;

    bfly_pkt_injector_if #(.CHANNEL_WIDTH(18)) bus ();

    bfly_pkt_injector #(
        .CHANNEL_WIDTH (18),
        .SRC_ID        (6'd5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks one flit cycle: the flit, the pkt_done pulse and both ready signals.
    task automatic check_cycle(input string tag, input logic [17:0] flit, input logic done,
                               input logic mrdy, input logic drdy);
        check({tag, "_flit"}, bus.out_ch, flit);
        check({tag, "_done"}, {17'd0, bus.pkt_done}, {17'd0, done});
        check({tag, "_mrdy"}, {17'd0, bus.msg_ready}, {17'd0, mrdy});
        check({tag, "_drdy"}, {17'd0, bus.data_ready}, {17'd0, drdy});
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.msg_valid  = 1'b1;
        bus.msg_dest   = 6'b10_01_11;
        bus.msg_len    = 4'd2;
        bus.data_valid = 1'b0;
        bus.data       = 10'h000;

        // Reset held for 3 cycles with msg_valid high.
        for (int i = 0; i < 3; i++) begin
            step();
            check_cycle("reset", 18'h0, 1'b0, 1'b0, 1'b0);
        end

        // Leave reset with nothing offered.
        rst_n         = 1'b1;
        bus.msg_valid = 1'b0;
        step();
        check_cycle("idle0", 18'h0, 1'b0, 1'b1, 1'b0);
        check("idle0_state", {17'd0, dbg_state}, 18'd0);

        // Single packet: dest 10_01_11, len 2, data 1/2/3.
        // data_valid is already high in IDLE, where it must be ignored.
        bus.msg_valid  = 1'b1;
        bus.msg_dest   = 6'b10_01_11;
        bus.msg_len    = 4'd2;
        bus.data_valid = 1'b1;
        bus.data       = 10'h001;
        step();
        check_cycle("p1_head", 18'b01_100111_0010_000101, 1'b0, 1'b0, 1'b1);
        bus.msg_valid = 1'b0;
        step();
        check_cycle("p1_body1", 18'b10_100111_0000000001, 1'b0, 1'b0, 1'b1);
        bus.data = 10'h002;
        step();
        check_cycle("p1_body2", 18'b10_100111_0000000010, 1'b0, 1'b0, 1'b1);
        bus.data = 10'h003;
        step();
        check_cycle("p1_tail", 18'b11_100111_0000000011, 1'b1, 1'b1, 1'b0);
        bus.data_valid = 1'b0;
        step();
        check_cycle("p1_after", 18'h0, 1'b0, 1'b1, 1'b0);

        // Single-word packet: len 0, data 0x3FF.
        bus.msg_valid = 1'b1;
        bus.msg_dest  = 6'b00_11_01;
        bus.msg_len   = 4'd0;
        step();
        check_cycle("p2_head", 18'b01_001101_0000_000101, 1'b0, 1'b0, 1'b1);
        bus.msg_valid  = 1'b0;
        bus.data_valid = 1'b1;
        bus.data       = 10'h3FF;
        step();
        check_cycle("p2_tail", 18'b11_001101_1111111111, 1'b1, 1'b1, 1'b0);
        bus.data_valid = 1'b0;
        step();
        check_cycle("p2_after", 18'h0, 1'b0, 1'b1, 1'b0);

        // Payload bubbles: len 3, two empty cycles after the first word.
        bus.msg_valid = 1'b1;
        bus.msg_dest  = 6'b11_10_00;
        bus.msg_len   = 4'd3;
        step();
        check_cycle("p3_head", 18'b01_111000_0011_000101, 1'b0, 1'b0, 1'b1);
        bus.msg_valid  = 1'b0;
        bus.data_valid = 1'b1;
        bus.data       = 10'h0AA;
        step();
        check_cycle("p3_body_aa", 18'b10_111000_0010101010, 1'b0, 1'b0, 1'b1);
        bus.data_valid = 1'b0;
        step();
        check_cycle("p3_bubble1", 18'h0, 1'b0, 1'b0, 1'b1);
        step();
        check_cycle("p3_bubble2", 18'h0, 1'b0, 1'b0, 1'b1);
        check("p3_bubble_state", {17'd0, dbg_state}, 18'd1);
        bus.data_valid = 1'b1;
        bus.data       = 10'h0BB;
        step();
        check_cycle("p3_body_bb", 18'b10_111000_0010111011, 1'b0, 1'b0, 1'b1);
        bus.data = 10'h0CC;
        step();
        check_cycle("p3_body_cc", 18'b10_111000_0011001100, 1'b0, 1'b0, 1'b1);
        bus.data = 10'h0DD;
        step();
        check_cycle("p3_tail_dd", 18'b11_111000_0011011101, 1'b1, 1'b1, 1'b0);
        bus.data_valid = 1'b0;
        step();
        check_cycle("p3_after", 18'h0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: msg_valid stays high across two descriptors.
        bus.msg_valid = 1'b1;
        bus.msg_dest  = 6'b01_01_01;
        bus.msg_len   = 4'd1;
        step();
        check_cycle("b2b_head1", 18'b01_010101_0001_000101, 1'b0, 1'b0, 1'b1);
        // The second descriptor waits; BODY must not accept it.
        bus.msg_dest   = 6'b00_00_11;
        bus.msg_len    = 4'd0;
        bus.data_valid = 1'b1;
        bus.data       = 10'h011;
        step();
        check_cycle("b2b_body1", 18'b10_010101_0000010001, 1'b0, 1'b0, 1'b1);
        bus.data = 10'h012;
        step();
        check_cycle("b2b_tail1", 18'b11_010101_0000010010, 1'b1, 1'b1, 1'b0);
        step();
        check_cycle("b2b_head2", 18'b01_000011_0000_000101, 1'b0, 1'b0, 1'b1);
        bus.msg_valid = 1'b0;
        bus.data      = 10'h013;
        step();
        check_cycle("b2b_tail2", 18'b11_000011_0000010011, 1'b1, 1'b1, 1'b0);
        bus.data_valid = 1'b0;
        step();
        check_cycle("b2b_after", 18'h0, 1'b0, 1'b1, 1'b0);

        // Reset after the head and one body flit.
        bus.msg_valid = 1'b1;
        bus.msg_dest  = 6'b11_01_10;
        bus.msg_len   = 4'd3;
        step();
        check_cycle("mr_head", 18'b01_110110_0011_000101, 1'b0, 1'b0, 1'b1);
        bus.msg_valid  = 1'b0;
        bus.data_valid = 1'b1;
        bus.data       = 10'h055;
        step();
        check_cycle("mr_body", 18'b10_110110_0001010101, 1'b0, 1'b0, 1'b1);
        rst_n          = 1'b0;
        bus.data_valid = 1'b0;
        step();
        check_cycle("mr_in_reset", 18'h0, 1'b0, 1'b0, 1'b0);
        check("mr_state", {17'd0, dbg_state}, 18'd0);
        rst_n = 1'b1;
        #1;
        check("mr_released_mrdy", {17'd0, bus.msg_ready}, 18'd1);

        // A fresh packet completes normally after the truncated one.
        bus.msg_valid = 1'b1;
        bus.msg_dest  = 6'b00_00_01;
        bus.msg_len   = 4'd1;
        step();
        check_cycle("mr_new_head", 18'b01_000001_0001_000101, 1'b0, 1'b0, 1'b1);
        bus.msg_valid  = 1'b0;
        bus.data_valid = 1'b1;
        bus.data       = 10'h066;
        step();
        check_cycle("mr_new_body", 18'b10_000001_0001100110, 1'b0, 1'b0, 1'b1);
        bus.data = 10'h077;
        step();
        check_cycle("mr_new_tail", 18'b11_000001_0001110111, 1'b1, 1'b1, 1'b0);
        bus.data_valid = 1'b0;
        step();
        check_cycle("mr_new_after", 18'h0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bfly_pkt_injector.md
Name: bfly_pkt_injector

Overview:
- Terminal-side packet source for the radix-4 symmetric butterfly.
- Accepts a message descriptor and a payload word stream from the host.
- Formats them into 18-bit flits (head, body, tail) and drives one switch-node input channel, one flit per cycle.
- Builds the route field so each stage consumes its digit from [15:14] and rotates it down.

Parameters:
- CHANNEL_WIDTH, 18, flit width; fixed at 18, other values are unsupported.
- SRC_ID, 0, 6-bit terminal id of this injector, inserted into the head flit.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- msg_valid  input  1  descriptor valid
- msg_ready  output  1  descriptor accepted when msg_valid & msg_ready
- msg_dest  input  6  destination terminal; [5:4] stage-0 digit, [3:2] stage-1 digit, [1:0] stage-2 digit
- msg_len  input  4  payload word count minus 1 (1..16 words)
- data_valid  input  1  payload word valid
- data_ready  output  1  payload word accepted when data_valid & data_ready
- data  input  10  payload word
- out_ch  output  CHANNEL_WIDTH  flit to switch-node input channel (registered)
- pkt_done  output  1  one-cycle pulse, registered with the tail flit

Behaviour:
- Flit format:
  - [17:16] type: 00 idle, 01 head, 10 body, 11 tail.
  - [15:10] route.
  - [9:0] payload.
- Head flit:
  - type 01, route = msg_dest unchanged.
  - [9:6] = msg_len, [5:0] = SRC_ID.
- Body/tail flits:
  - Route field = route latched from the descriptor; switch nodes ignore it.
  - [9:0] = data word.
- Idle flit is all zeros.
- Reset (rst_n low at posedge):
  - state <= IDLE; out_ch <= 0; pkt_done <= 0.
  - Word counter and latched dest/len cleared.
  - msg_ready and data_ready are combinational from state and are 0 while rst_n is low.
- State machine, IDLE / BODY:
  - IDLE: msg_ready = 1, data_ready = 0.
    - On a handshake at edge N: latch dest and len, load cnt <= 0, out_ch <= head flit (visible after edge N), go to BODY.
    - With no handshake: out_ch <= idle.
  - BODY: msg_ready = 0, data_ready = 1.
    - On a data handshake with cnt < len: out_ch <= body flit, cnt <= cnt + 1.
    - On a data handshake with cnt == len: out_ch <= tail flit, pkt_done <= 1, go to IDLE.
    - With no data_valid: out_ch <= idle flit (bubble). The packet stays open and cnt holds.
- Latency: one cycle from any accepted handshake to the corresponding flit on out_ch.
- Throughput:
  - Back-to-back packets with no idle gap: tail at cycle T+1, next head can be accepted at edge T+1 and appear at T+2.
  - Packet of L words occupies L+1 flit slots minimum.
- Single-word packet (msg_len = 0): head followed directly by a tail flit; no body flits.
- No downstream backpressure; the butterfly channel always sinks a flit per cycle.
- cnt is 4 bits; it never exceeds len, so no wrap-around.
- data_valid in IDLE is ignored (data_ready = 0). msg_valid in BODY is held off (msg_ready = 0).
- Reset mid-packet: packet truncated with no tail emitted. The next cycle out_ch = idle; the host must reissue.
- pkt_done is 0 in every cycle except the tail-flit cycle.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with msg_valid = 1 -> out_ch = 0, msg_ready = 0, data_ready = 0, pkt_done = 0 throughout.
- Single packet, SRC_ID = 5, msg_dest = 6'b10_01_11, msg_len = 2, data 0x001/0x002/0x003 presented continuously ->
  - head 18'b01_100111_0010_000101
  - body 0x001, body 0x002
  - tail 0x003 on consecutive cycles; pkt_done high with the tail only.
- Single-word packet, msg_len = 0, data = 0x3FF -> head then tail (type 11, payload 0x3FF) on the next cycle; no body flits.
- Payload bubbles: len = 3, data_valid low for 2 cycles after the first word -> two idle flits inserted, remaining flits unchanged, tail count correct.
- Back-to-back: msg_valid held high with two descriptors -> second head appears the cycle after the first tail; no idle gap.
- Reset mid-packet after head plus 1 body flit -> next out_ch = 0, state IDLE, msg_ready = 1 after rst_n released; a new packet completes normally.
